// File: rtl/booth_r4_seq_mult_if.sv
// Operand/product handshake bundle for the radix-4 Booth multiplier.
// master = upstream producer/downstream consumer side, slave = multiplier.
interface booth_r4_seq_mult_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 is_signed;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;
    logic [2:0]           digit;

    modport master (
        output in_valid, a, b, is_signed, out_ready,
        input  in_ready, out_valid, product, digit
    );

    modport slave (
        input  in_valid, a, b, is_signed, out_ready,
        output in_ready, out_valid, product, digit
    );
endinterface

// File: rtl/booth_r4_seq_mult.sv
// Iterative radix-4 Booth multiplier: one Booth digit retired per clock
// through a shared shift-add datapath, signed or unsigned per transaction.
module booth_r4_seq_mult #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    booth_r4_seq_mult_if.slave bus
);
    localparam int EW   = WIDTH + 2;
    localparam int AW   = 2 * WIDTH + 4;
    localparam int ITER = WIDTH / 2 + 1;
    localparam int CW   = $clog2(ITER + 1);

    generate
        if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_width
            $error("booth_r4_seq_mult: WIDTH must be even and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [AW-1:0]       r_acc;
    logic [AW-1:0]       r_ma;
    logic [EW-1:0]       r_mb;
    logic                r_prev;
    logic [CW-1:0]       r_cnt;
    logic [2*WIDTH-1:0]  r_product;

    logic [EW-1:0]       w_a_ext;
    logic [EW-1:0]       w_b_ext;
    logic [2:0]          w_trip;
    logic [2:0]          w_dig;
    logic [AW-1:0]       w_term;
    logic [AW-1:0]       w_acc_nxt;
    logic                w_accept;
    logic                w_last;
    logic                w_in_ready;
    logic                w_out_valid;

    assign w_a_ext = bus.is_signed ? {{2{bus.a[WIDTH-1]}}, bus.a}
                                   : {2'b00, bus.a};
    assign w_b_ext = bus.is_signed ? {{2{bus.b[WIDTH-1]}}, bus.b}
                                   : {2'b00, bus.b};

    assign w_trip    = {r_mb[1], r_mb[0], r_prev};
    assign w_accept  = bus.in_valid && w_in_ready;
    assign w_last    = (r_cnt == CW'(ITER - 1));
    assign w_acc_nxt = r_acc + w_term;

    // Booth recoding of the current multiplier triplet into {neg, mag}
    always_comb begin
        w_dig = 3'b000;
        unique case (w_trip)
            3'b001, 3'b010: w_dig = 3'b001;
            3'b011:         w_dig = 3'b010;
            3'b100:         w_dig = 3'b110;
            3'b101, 3'b110: w_dig = 3'b101;
            default:        w_dig = 3'b000;
        endcase
    end

    // Partial product selected by the digit; r_ma already carries the 4^i weight
    always_comb begin
        w_term = '0;
        unique case (w_dig)
            3'b001:  w_term = r_ma;
            3'b010:  w_term = r_ma << 1;
            3'b101:  w_term = -r_ma;
            3'b110:  w_term = -(r_ma << 1);
            default: w_term = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_next = S_CALC;
                end
            end
            S_CALC: begin
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Operand capture, shift-add iteration and product register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc     <= '0;
            r_ma      <= '0;
            r_mb      <= '0;
            r_prev    <= 1'b0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_acc  <= '0;
            r_ma   <= {{(AW-EW){w_a_ext[EW-1]}}, w_a_ext};
            r_mb   <= w_b_ext;
            r_prev <= 1'b0;
            r_cnt  <= '0;
        end else if (r_state == S_CALC) begin
            r_acc  <= w_acc_nxt;
            r_ma   <= r_ma << 2;
            r_mb   <= r_mb >> 2;
            r_prev <= r_mb[1];
            r_cnt  <= r_cnt + 1'b1;
            if (w_last) begin
                r_product <= w_acc_nxt[2*WIDTH-1:0];
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.product   = r_product;
    assign bus.digit     = (r_state == S_CALC) ? w_dig : 3'b000;
endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Directed bench for booth_r4_seq_mult at WIDTH=8 and WIDTH=16.
// Expected products are hand-computed or taken from a plain multiply.
module tb_booth_r4_seq_mult;
    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;
    logic [2:0] dlog [0:63];

    booth_r4_seq_mult_if #(.WIDTH(8))  if8 ();
    booth_r4_seq_mult_if #(.WIDTH(16)) if16 ();

    booth_r4_seq_mult #(.WIDTH(8)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (if8)
    );

    booth_r4_seq_mult #(.WIDTH(16)) u_dut16 (
        .clk (clk),
        .rst (rst),
        .bus (if16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run8(input logic [7:0] ta, input logic [7:0] tb_,
                        input logic ts, output logic [15:0] prod,
                        output int lat);
        int g;
        g = 0;
        while (!if8.in_ready && g < 100) begin
            @(posedge clk); #1; g++;
        end
        if8.a = ta; if8.b = tb_; if8.is_signed = ts;
        if8.in_valid = 1'b1;
        @(posedge clk); #1;
        if8.in_valid = 1'b0;
        if8.a = 8'h5A; if8.b = 8'hA5; if8.is_signed = ~ts;
        lat = 0;
        while (!if8.out_valid && lat < 40) begin
            dlog[lat] = if8.digit;
            @(posedge clk); #1; lat++;
        end
        prod = if8.product;
    endtask

    task automatic run16(input logic [15:0] ta, input logic [15:0] tb_,
                         input logic ts, output logic [31:0] prod,
                         output int lat);
        int g;
        g = 0;
        while (!if16.in_ready && g < 100) begin
            @(posedge clk); #1; g++;
        end
        if16.a = ta; if16.b = tb_; if16.is_signed = ts;
        if16.in_valid = 1'b1;
        @(posedge clk); #1;
        if16.in_valid = 1'b0;
        lat = 0;
        while (!if16.out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        prod = if16.product;
    endtask

    task automatic finish8();
        if8.out_ready = 1'b1;
        @(posedge clk); #1;
        if8.out_ready = 1'b0;
    endtask

    task automatic finish16();
        if16.out_ready = 1'b1;
        @(posedge clk); #1;
        if16.out_ready = 1'b0;
    endtask

    function automatic logic [15:0] ref8(input logic [7:0] x,
                                         input logic [7:0] y,
                                         input logic s);
        longint px, py;
        px = s ? longint'($signed(x)) : longint'(x);
        py = s ? longint'($signed(y)) : longint'(y);
        return 16'(px * py);
    endfunction

    function automatic logic [31:0] ref16(input logic [15:0] x,
                                          input logic [15:0] y,
                                          input logic s);
        longint px, py;
        px = s ? longint'($signed(x)) : longint'(x);
        py = s ? longint'($signed(y)) : longint'(y);
        return 32'(px * py);
    endfunction

    initial begin
        logic [15:0] p8;
        logic [31:0] p16;
        logic [7:0]  ra, rb;
        logic [15:0] ra16, rb16;
        int          lat;

        n_assert = 0;
        n_fail   = 0;
        rst = 1'b1;
        if8.in_valid = 1'b0; if8.out_ready = 1'b0;
        if8.a = '0; if8.b = '0; if8.is_signed = 1'b0;
        if16.in_valid = 1'b0; if16.out_ready = 1'b0;
        if16.a = '0; if16.b = '0; if16.is_signed = 1'b0;

        #12;
        check("rst_in_ready", 64'(if8.in_ready), 64'd1);
        check("rst_out_valid", 64'(if8.out_valid), 64'd0);
        check("rst_product", 64'(if8.product), 64'd0);
        check("rst_digit", 64'(if8.digit), 64'd0);
        check("rst16_product", 64'(if16.product), 64'd0);
        #3 rst = 1'b0;
        @(posedge clk); #1;

        // signed -128 * -128
        run8(8'h80, 8'h80, 1'b1, p8, lat);
        check("s80x80_lat", 64'(lat), 64'd5);
        check("s80x80_prod", 64'(p8), 64'h4000);
        finish8();

        // unsigned 255*255, signed -1*-1
        run8(8'hFF, 8'hFF, 1'b0, p8, lat);
        check("uFFxFF_prod", 64'(p8), 64'hFE01);
        finish8();
        run8(8'hFF, 8'hFF, 1'b1, p8, lat);
        check("sFFxFF_prod", 64'(p8), 64'h0001);
        finish8();

        // digit trace for 127*3: -1, +1, 0, 0, 0
        run8(8'h7F, 8'h03, 1'b1, p8, lat);
        check("d0", 64'(dlog[0]), 64'b101);
        check("d1", 64'(dlog[1]), 64'b001);
        check("d2", 64'(dlog[2]), 64'b000);
        check("d3", 64'(dlog[3]), 64'b000);
        check("d4", 64'(dlog[4]), 64'b000);
        check("s7Fx03_prod", 64'(p8), 64'h017D);
        check("done_digit", 64'(if8.digit), 64'd0);
        finish8();

        // back-pressure: 0x12*0x34 = 0x03A8 held while out_ready=0
        run8(8'h12, 8'h34, 1'b0, p8, lat);
        check("bp_prod", 64'(p8), 64'h03A8);
        for (int i = 0; i < 10; i++) begin
            if8.in_valid = i[0];
            if8.a = 8'h55; if8.b = 8'h33;
            @(posedge clk); #1;
            check("bp_hold_prod", 64'(if8.product), 64'h03A8);
            check("bp_out_valid", 64'(if8.out_valid), 64'd1);
            check("bp_in_ready", 64'(if8.in_ready), 64'd0);
        end
        if8.in_valid = 1'b0;
        finish8();
        check("bp_release_ov", 64'(if8.out_valid), 64'd0);
        check("bp_release_ir", 64'(if8.in_ready), 64'd1);

        // asynchronous reset in the middle of CALC
        if8.a = 8'h33; if8.b = 8'h77; if8.is_signed = 1'b0;
        if8.in_valid = 1'b1;
        @(posedge clk); #1;
        if8.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 64'(if8.out_valid), 64'd0);
        check("arst_in_ready", 64'(if8.in_ready), 64'd1);
        check("arst_product", 64'(if8.product), 64'd0);
        check("arst_digit", 64'(if8.digit), 64'd0);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        run8(8'h80, 8'h7F, 1'b1, p8, lat);
        check("post_rst_lat", 64'(lat), 64'd5);
        check("post_rst_prod", 64'(p8), 64'hC080);
        finish8();

        // randomised back-to-back, both modes
        for (int i = 0; i < 12; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            run8(ra, rb, i[0], p8, lat);
            check("rand8_prod", 64'(p8), 64'(ref8(ra, rb, i[0])));
            finish8();
        end

        // WIDTH=16 corner: -32768 * 32767
        run16(16'h8000, 16'h7FFF, 1'b1, p16, lat);
        check("w16_lat", 64'(lat), 64'd9);
        check("w16_prod", 64'(p16), 64'hC0008000);
        finish16();
        run16(16'hFFFF, 16'hFFFF, 1'b0, p16, lat);
        check("w16_umax", 64'(p16), 64'hFFFE0001);
        finish16();
        for (int i = 0; i < 6; i++) begin
            ra16 = 16'($urandom);
            rb16 = 16'($urandom);
            run16(ra16, rb16, i[0], p16, lat);
            check("rand16_prod", 64'(p16), 64'(ref16(ra16, rb16, i[0])));
            finish16();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
